// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using shift-and-add-3.
// One conversion takes W shift cycles plus a single DONE cycle. The packed
// BCD result and leading-zero mask are held until the next completion.
module bin2bcd_seq #(
  parameter int W  = 8,
  parameter int ND = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    bin,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] bcd,
  output logic [ND-1:0]   lz
);

  localparam int CW = $clog2(W + 1);
  // The reset mask blanks every digit except the units digit, so the display reads "0".
  localparam logic [ND-1:0] LZ_RST = {ND{1'b1}} ^ ND'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q;
  logic [W-1:0]    shift_q;
  logic [4*ND-1:0] scratch_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [4*ND-1:0] bcd_q;
  logic [ND-1:0]   lz_q;

  logic [4*ND-1:0] adjScratch;
  logic [4*ND-1:0] scratch_d;
  logic [W-1:0]    shift_d;
  logic [ND-1:0]   lz_d;

  // One shift step: add 3 to each digit >= 5 (no inter-digit carry), then shift {scratch, shift} left.
  always_comb begin
    adjScratch = scratch_q;
    for (int i = 0; i < ND; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adjScratch[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    scratch_d = {adjScratch[4*ND-2:0], shift_q[W-1]};
    shift_d   = {shift_q[W-2:0], 1'b0};
  end

  // Leading-zero mask of the post-shift scratch: digit i blanks when it and every higher digit are zero.
  always_comb begin : lzCalc
    logic zeroAbove;
    zeroAbove = 1'b1;
    lz_d      = '0;
    for (int i = ND - 1; i >= 1; i--) begin
      zeroAbove = zeroAbove & (scratch_d[4*i +: 4] == 4'd0);
      lz_d[i]   = zeroAbove;
    end
  end

  // Control FSM with the datapath registers and registered busy/done/bcd/lz outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      lz_q      <= LZ_RST;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= bin;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          shift_q   <= shift_d;
          scratch_q <= scratch_d;
          cnt_q     <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            bcd_q   <= scratch_d;
            lz_q    <= lz_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign lz   = lz_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: table-driven and scoreboard checks for bin2bcd_seq (W=8, ND=3).
// A cycle-level reference model predicts busy/done and pushes decimal results
// into a queue on each accepted start; a negedge checker pops and compares them.
module tb_bin2bcd_seq;

  localparam int W  = 8;
  localparam int ND = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [W-1:0]    bin = '0;
  logic            busy;
  logic            done;
  logic [4*ND-1:0] bcd;
  logic [ND-1:0]   lz;

  bin2bcd_seq #(.W(W), .ND(ND)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .bcd  (bcd),
    .lz   (lz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]    bin;
    logic [4*ND-1:0] expBcd;
    logic [ND-1:0]   expLz;
  } vec_t;

  typedef struct {
    logic [4*ND-1:0] bcd;
    logic [ND-1:0]   lz;
  } exp_t;

  typedef enum int {M_IDLE, M_SHIFT, M_DONE} mstate_t;

  int      total = 0;
  int      bad = 0;
  exp_t    expQ[$];
  mstate_t mState = M_IDLE;
  int      mCnt = 0;
  int      cyc = 0;
  int      rstCount = 0;
  int      doneCount = 0;
  bit      streamMode = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Decimal reference: integer division into digits, then the leading-zero rule.
  function automatic exp_t decimalModel(input int value);
    exp_t r;
    int   v;
    bit   zeroAbove;
    v = value;
    r.bcd = '0;
    r.lz  = '0;
    for (int d = 0; d < ND; d++) begin
      r.bcd[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    zeroAbove = 1'b1;
    for (int d = ND - 1; d >= 1; d--) begin
      zeroAbove = zeroAbove && (r.bcd[4*d +: 4] == 4'd0);
      r.lz[d] = zeroAbove;
    end
    return r;
  endfunction

  // Cycle-level reference model of the handshake; queues an expected result per accepted start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mState = M_IDLE;
      mCnt   = 0;
      expQ.delete();
      rstCount++;
    end else begin
      cyc++;
      case (mState)
        M_IDLE: if (start) begin
          expQ.push_back(decimalModel(int'(bin)));
          mCnt   = 0;
          mState = M_SHIFT;
        end
        M_SHIFT: begin
          mCnt++;
          if (mCnt == W) mState = M_DONE;
        end
        default: mState = M_IDLE;
      endcase
    end
  end

  logic [4*ND-1:0] prevBcd = '0;
  logic [ND-1:0]   prevLz = 3'b110;
  int              seenRst = 0;
  bit              prevBusy = 1'b0;
  bit              prevStream = 1'b0;
  bit              haveRise = 1'b0;
  int              lastRise = 0;

  // Negedge checker: busy/done against the model, scoreboard pop on done, output stability, start spacing.
  always @(negedge clk) begin
    exp_t e;
    checkOutput("busy", int'(busy), int'(mState == M_SHIFT));
    checkOutput("done", int'(done), int'(mState == M_DONE));
    if (done) doneCount++;
    if (mState == M_DONE) begin
      if (expQ.size() == 0) begin
        checkOutput("scoreboardEmpty", 0, 1);
      end else begin
        e = expQ.pop_front();
        checkOutput("sbBcd", int'(bcd), int'(e.bcd));
        checkOutput("sbLz", int'(lz), int'(e.lz));
      end
    end
    if (bcd != prevBcd || lz != prevLz) begin
      checkOutput("outputStable", int'(mState == M_DONE || rstCount != seenRst), 1);
    end
    prevBcd = bcd;
    prevLz  = lz;
    seenRst = rstCount;
    if (streamMode && !prevStream) haveRise = 1'b0;
    if (streamMode && busy && !prevBusy) begin
      if (haveRise) checkOutput("startSpacing", cyc - lastRise, W + 2);
      haveRise = 1'b1;
      lastRise = cyc;
    end
    prevBusy   = busy;
    prevStream = streamMode;
  end

  // Wait for a done pulse at a negedge, with a bounded cycle budget.
  task automatic waitDone();
    for (int i = 0; i < 40; i++) begin
      if (done) return;
      @(negedge clk);
    end
    checkOutput("doneTimeout", 0, 1);
  endtask

  // Launch one conversion, scramble bin after capture, and wait for done.
  task automatic applyStimulus(input logic [W-1:0] value);
    @(negedge clk);
    start = 1'b1;
    bin   = value;
    @(negedge clk);
    start = 1'b0;
    bin   = W'($urandom);
    waitDone();
  endtask

  vec_t vecs[10];
  int   d0;

  initial begin
    vecs[0] = '{8'd255, 12'h255, 3'b000};
    vecs[1] = '{8'd0,   12'h000, 3'b110};
    vecs[2] = '{8'd7,   12'h007, 3'b110};
    vecs[3] = '{8'd40,  12'h040, 3'b100};
    vecs[4] = '{8'd9,   12'h009, 3'b110};
    vecs[5] = '{8'd10,  12'h010, 3'b100};
    vecs[6] = '{8'd99,  12'h099, 3'b100};
    vecs[7] = '{8'd100, 12'h100, 3'b000};
    vecs[8] = '{8'd199, 12'h199, 3'b000};
    vecs[9] = '{8'd128, 12'h128, 3'b000};

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstBcd", int'(bcd), 0);
    checkOutput("rstLz", int'(lz), 3'b110);
    rst = 1'b0;

    // Start accepted on the first edge after reset release; busy lasts exactly W cycles.
    start = 1'b1;
    bin   = 8'd255;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      checkOutput("busyWindow", int'(busy), 1);
      @(negedge clk);
    end
    checkOutput("firstDone", int'(done), 1);
    checkOutput("firstBcd", int'(bcd), 12'h255);
    checkOutput("firstLz", int'(lz), 3'b000);
    @(negedge clk);
    checkOutput("donePulseOneCycle", int'(done), 0);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].bin);
      checkOutput($sformatf("vecBcd%0d", vecs[i].bin), int'(bcd), int'(vecs[i].expBcd));
      checkOutput($sformatf("vecLz%0d", vecs[i].bin), int'(lz), int'(vecs[i].expLz));
    end

    // start ignored mid-SHIFT and during DONE.
    @(negedge clk);
    d0 = doneCount;
    start = 1'b1;
    bin   = 8'd123;
    @(negedge clk);
    start = 1'b0;
    bin   = 8'd99;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("ignoreBcd", int'(bcd), 12'h123);
    checkOutput("ignoreDoneCount", doneCount - d0, 1);

    // Reset after the 4th shift edge aborts the conversion immediately.
    d0 = doneCount;
    start = 1'b1;
    bin   = 8'd200;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortDone", int'(done), 0);
    checkOutput("abortBcd", int'(bcd), 0);
    checkOutput("abortLz", int'(lz), 3'b110);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("abortNoDone", doneCount - d0, 0);
    checkOutput("abortBcdHeld", int'(bcd), 0);
    applyStimulus(8'd5);
    checkOutput("afterAbortBcd", int'(bcd), 12'h005);
    checkOutput("afterAbortLz", int'(lz), 3'b110);

    // Back-to-back: start held high, bin stepping every cycle.
    @(negedge clk);
    streamMode = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 2600; i++) begin
      bin = W'(i);
      @(negedge clk);
    end
    start = 1'b0;
    streamMode = 1'b0;
    repeat (12) @(negedge clk);

    // Random sweep with random idle gaps.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(W'($urandom));
    end
    repeat (12) @(negedge clk);
    checkOutput("scoreboardDrained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
